pd_loop_filter_mp: RTL and testbench

Parametrised phase detector and second-order loop filter for the carrier-recovery loop. It sits between the I/Q matched-filter/decimation output and the NCO frequency-word input. It is the successor to the fixed 28/34-bit BPSK detector/filter and adds the following:
- generic widths and update period;
- runtime-selectable BPSK/QPSK detector;
- runtime shift coefficients;
- saturating accumulation, integrator hold/clear;
- an output-valid strobe.

---
 rtl/pd_lf_pkg.sv | 13 +
 rtl/sat_add.sv | 23 ++
 rtl/pd_loop_filter_mp.sv | 99 +++++++++
 tb/tb_pd_loop_filter_mp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_lf_pkg.sv
// Shared constants for the carrier-recovery phase detector / loop filter.
package pd_lf_pkg;

    typedef enum logic {
        PD_MODE_BPSK = 1'b0,
        PD_MODE_QPSK = 1'b1
    } pd_mode_e;

    // Slot positions counted back from the end of the update period.
    localparam int unsigned INT_SLOT_OFS = 4;
    localparam int unsigned OUT_SLOT_OFS = 3;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder with saturation to the W-bit range and a clamp indicator.
module sat_add #(
    parameter int unsigned W = 34
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c,
    output logic                clamp_c
);

    logic signed [W:0] full_c;

    always_comb begin
        full_c  = {a[W-1], a} + {b[W-1], b};
        clamp_c = (full_c[W] != full_c[W-1]);
        sum_c   = full_c[W-1:0];
        // Top two bits disagree: overflow, clamp toward the true sign.
        if (clamp_c) begin
            sum_c = full_c[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pd_loop_filter_mp.sv
// BPSK/QPSK phase detector feeding a second-order loop filter that emits one
// saturated frequency word per 2^PERIOD_W clocks for the NCO.
module pd_loop_filter_mp
    import pd_lf_pkg::*;
#(
    parameter int unsigned DW       = 28,
    parameter int unsigned OW       = 34,
    parameter int unsigned PERIOD_W = 4,
    parameter int unsigned SHIFT_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [DW-1:0] di,
    input  logic signed [DW-1:0] dq,
    input  logic                mode,
    input  logic [SHIFT_W-1:0]  k1_shift,
    input  logic [SHIFT_W-1:0]  k2_shift,
    input  logic                hold,
    input  logic                clear_int,
    output logic signed [OW-1:0] frequency_df,
    output logic                freq_vld,
    output logic                sat_flag
);

    localparam int unsigned PDW = DW + 2;
    localparam logic [PERIOD_W-1:0] INT_SLOT = PERIOD_W'((1 << PERIOD_W) - INT_SLOT_OFS);
    localparam logic [PERIOD_W-1:0] OUT_SLOT = PERIOD_W'((1 << PERIOD_W) - OUT_SLOT_OFS);

    logic signed [PDW-1:0] pd;
    logic [PERIOD_W-1:0]   cnt;
    logic signed [OW-1:0]  integ;

    logic signed [PDW-1:0] di_x_c, dq_x_c, si_c, sq_c, pd_next_c;
    logic signed [OW-1:0]  pd_ext_c, int_inc_c, prop_c, int_sum_c, out_sum_c;
    logic                  int_clamp_c, out_clamp_c, int_slot_c, out_slot_c, int_upd_c;

    // Detector: widened before negation so -2^(DW-1) cannot wrap.
    always_comb begin
        di_x_c    = PDW'(di);
        dq_x_c    = PDW'(dq);
        si_c      = di[DW-1] ? -dq_x_c : dq_x_c;
        sq_c      = dq[DW-1] ? -di_x_c : di_x_c;
        pd_next_c = (mode == PD_MODE_QPSK) ? (si_c - sq_c) : si_c;
    end

    // Gain shifts are arithmetic, so large shifts settle at 0 or -1.
    always_comb begin
        pd_ext_c   = OW'(pd);
        int_inc_c  = pd_ext_c >>> k1_shift;
        prop_c     = pd_ext_c >>> k2_shift;
        int_slot_c = (cnt == INT_SLOT);
        out_slot_c = (cnt == OUT_SLOT);
        int_upd_c  = int_slot_c && !hold;
    end

    sat_add #(.W(OW)) u_int_add (
        .a       (integ),
        .b       (int_inc_c),
        .sum_c   (int_sum_c),
        .clamp_c (int_clamp_c)
    );

    sat_add #(.W(OW)) u_out_add (
        .a       (integ),
        .b       (prop_c),
        .sum_c   (out_sum_c),
        .clamp_c (out_clamp_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pd           <= '0;
            cnt          <= '0;
            integ        <= '0;
            frequency_df <= '0;
            freq_vld     <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            pd       <= pd_next_c;
            cnt      <= cnt + PERIOD_W'(1);
            freq_vld <= out_slot_c;
            if (out_slot_c) begin
                frequency_df <= out_sum_c;
            end
            if (clear_int) begin
                integ <= '0;
            end else if (int_upd_c) begin
                integ <= int_sum_c;
            end
            // Clear wins over any clamp seen in the same cycle.
            if (clear_int) begin
                sat_flag <= 1'b0;
            end else if ((int_upd_c && int_clamp_c) || (out_slot_c && out_clamp_c)) begin
                sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pd_loop_filter_mp.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// arithmetic reference model of the detector and loop filter.
module tb_pd_loop_filter_mp;

    localparam int unsigned DW     = 28;
    localparam int unsigned OW     = 34;
    localparam int unsigned PW     = 4;
    localparam int unsigned SW     = 5;
    localparam int          PERIOD = 1 << PW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] di, dq;
    logic                 mode;
    logic [SW-1:0]        k1_shift, k2_shift;
    logic                 hold, clear_int;
    logic signed [OW-1:0] frequency_df;
    logic                 freq_vld, sat_flag;

    int checks;
    int failures;
    int e;

    longint m_pd, m_integ, m_fd;
    int     m_cnt;
    bit     m_vld, m_sat;

    pd_loop_filter_mp #(.DW(DW), .OW(OW), .PERIOD_W(PW), .SHIFT_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .di           (di),
        .dq           (dq),
        .mode         (mode),
        .k1_shift     (k1_shift),
        .k2_shift     (k2_shift),
        .hold         (hold),
        .clear_int    (clear_int),
        .frequency_df (frequency_df),
        .freq_vld     (freq_vld),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", tag, obs, exp, $time, e);
        end
    endtask

    function automatic longint floor_shift(input longint v, input int k);
        longint p;
        p = longint'(1) <<< k;
        if (v >= 0) return v / p;
        return -(((-v) + p - 1) / p);
    endfunction

    function automatic longint clamp_ow(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint detect(input longint a, input longint b, input bit qpsk);
        longint si, sq;
        si = (a >= 0) ? b : -b;
        sq = (b >= 0) ? a : -a;
        return qpsk ? (si - sq) : si;
    endfunction

    task automatic m_reset();
        m_pd = 0; m_integ = 0; m_fd = 0; m_cnt = 0; m_vld = 0; m_sat = 0;
    endtask

    // One rising edge of the reference model, using the inputs held over that edge.
    task automatic m_edge();
        longint s, nint;
        bit     nsat;
        nint = m_integ;
        nsat = m_sat;
        if (m_cnt == PERIOD - 4 && !hold) begin
            s    = m_integ + floor_shift(m_pd, int'(k1_shift));
            nint = clamp_ow(s);
            if (s != nint) nsat = 1;
        end
        m_vld = (m_cnt == PERIOD - 3);
        if (m_vld) begin
            s    = m_integ + floor_shift(m_pd, int'(k2_shift));
            m_fd = clamp_ow(s);
            if (s != m_fd) nsat = 1;
        end
        if (clear_int) begin
            nint = 0;
            nsat = 0;
        end
        m_integ = nint;
        m_sat   = nsat;
        m_pd    = detect(longint'(di), longint'(dq), mode);
        m_cnt   = (m_cnt + 1) % PERIOD;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_edge();
            e++;
        end else begin
            m_reset();
        end
        @(negedge clk);
        chk("df", longint'(frequency_df), m_fd);
        chk("vld", longint'(freq_vld), longint'(m_vld));
        chk("sat", longint'(sat_flag), longint'(m_sat));
    endtask

    task automatic run_to(input int n);
        while (e < n) step();
    endtask

    task automatic set_in(input longint a, input longint b, input bit md, input int k1, input int k2);
        di       = DW'(a);
        dq       = DW'(b);
        mode     = md;
        k1_shift = SW'(k1);
        k2_shift = SW'(k2);
    endtask

    // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_rst_df"}, longint'(frequency_df), 0);
        chk({tag, "_rst_vld"}, longint'(freq_vld), 0);
        chk({tag, "_rst_sat"}, longint'(sat_flag), 0);
        m_reset();
        e = 0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0; e = 0;
        rst = 1'b0; hold = 1'b0; clear_int = 1'b0;
        set_in(0, 0, 0, 0, 0);
        m_reset();
        #1;
        chk("init_df", longint'(frequency_df), 0);
        chk("init_vld", longint'(freq_vld), 0);
        chk("init_sat", longint'(sat_flag), 0);
        step();
        step();

        // BPSK, positive pd = 2048: integ +2, prop +64 per period.
        set_in(100, 2048, 0, 10, 5);
        rst = 1'b1;
        run_to(13);
        chk("a_vld_e13", longint'(freq_vld), 0);
        chk("a_df_e13", longint'(frequency_df), 0);
        run_to(14);
        chk("a_df_e14", longint'(frequency_df), 66);
        chk("a_vld_e14", longint'(freq_vld), 1);
        run_to(15);
        chk("a_vld_e15", longint'(freq_vld), 0);
        run_to(30);
        chk("a_df_e30", longint'(frequency_df), 68);
        chk("a_vld_e30", longint'(freq_vld), 1);
        run_to(46);
        chk("a_df_e46", longint'(frequency_df), 70);
        run_to(23 + 2 * PERIOD);

        // Reset at cnt = 7, then the BPSK sign-flip case.
        set_in(-100, 2048, 0, 10, 5);
        apply_reset("b");
        run_to(13);
        chk("b_vld_e13", longint'(freq_vld), 0);
        run_to(14);
        chk("b_df_e14", longint'(frequency_df), -66);
        chk("b_vld_e14", longint'(freq_vld), 1);
        run_to(30);
        chk("b_df_e30", longint'(frequency_df), -68);

        // QPSK, pd = 500, unity gains; then hold across three periods.
        set_in(1000, -500, 1, 0, 0);
        apply_reset("c");
        run_to(14);
        chk("c_df_e14", longint'(frequency_df), 1000);
        run_to(30);
        chk("c_df_e30", longint'(frequency_df), 1500);
        hold = 1'b1;
        run_to(46);
        chk("hold_df_e46", longint'(frequency_df), 1500);
        run_to(62);
        chk("hold_df_e62", longint'(frequency_df), 1500);
        run_to(78);
        chk("hold_df_e78", longint'(frequency_df), 1500);
        hold = 1'b0;
        run_to(94);
        chk("unhold_df_e94", longint'(frequency_df), 2000);

        // Integrator saturation and clear.
        set_in(1, (longint'(1) <<< (DW - 1)) - 1, 0, 0, 31);
        apply_reset("s");
        run_to(13 + 64 * PERIOD - PERIOD + 1);
        chk("s_df_64", longint'(frequency_df), 64 * ((longint'(1) <<< (DW - 1)) - 1));
        chk("s_sat_64", longint'(sat_flag), 0);
        run_to(14 + 64 * PERIOD);
        chk("s_df_clamp", longint'(frequency_df), (longint'(1) <<< (OW - 1)) - 1);
        chk("s_sat_clamp", longint'(sat_flag), 1);
        run_to(16 + 64 * PERIOD);
        clear_int = 1'b1;
        step();
        clear_int = 1'b0;
        chk("s_sat_clr", longint'(sat_flag), 0);
        run_to(14 + 65 * PERIOD);
        chk("s_df_after_clr", longint'(frequency_df), (longint'(1) <<< (DW - 1)) - 1);
        chk("s_sat_after_clr", longint'(sat_flag), 0);

        // Randomized traffic, every cycle checked against the model.
        for (int i = 0; i < 4000; i++) begin
            di        = DW'($urandom);
            dq        = DW'($urandom);
            if ($urandom_range(15, 0) == 0) di = {1'b1, {(DW - 1){1'b0}}};
            if ($urandom_range(15, 0) == 0) dq = {1'b1, {(DW - 1){1'b0}}};
            mode      = 1'($urandom);
            k1_shift  = ($urandom_range(3, 0) == 0) ? SW'($urandom) : SW'($urandom_range(2, 0));
            k2_shift  = SW'($urandom);
            hold      = ($urandom_range(3, 0) == 0);
            clear_int = ($urandom_range(63, 0) == 0);
            if ($urandom_range(999, 0) == 0) begin
                clear_int = 1'b0;
                apply_reset("rnd");
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
